core_controller_axil_master: RTL and testbench
==============================================

# core_controller_axil_master

AXI4-Lite master that turns single-beat register commands into AXI4-Lite read and write transactions. It drives the slave port of the core controller (CRST/CSTAT register map) from a simple valid/ready command port, which lets a test harness, boot sequencer or debug bridge control the core without a processor. The block allows one outstanding transaction, reports the AXI response code, and flags slaves that stall.

## Interface
- C_M_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_M_AXI_ADDR_WIDTH, 16, byte address width.
- TIMEOUT_CYCLES, 1024, wait-cycle limit before `timeout` is raised; minimum 2.

Ports:
- m_axi_aclk  in  1  single clock for the whole block.
- m_axi_aresetn  in  1  reset, asynchronous and active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR  byte address.
- cmd_wdata  in  DATA  write data.
- cmd_wstrb  in  DATA/8  write strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP, passed through unchanged.
- timeout  out  1  sticky flag: a wait exceeded TIMEOUT_CYCLES.
- timeout_clr  in  1  clears `timeout`.
- m_axi_aw{addr,prot,valid,ready}, m_axi_w{data,strb,valid,ready}, m_axi_b{resp,valid,ready}, m_axi_ar{addr,prot,valid,ready}, m_axi_r{data,resp,valid,ready}: standard AXI4-Lite master directions and widths.

## Operation
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE: `cmd_ready`=1. A handshake (`cmd_valid && cmd_ready`) latches addr, wdata, wstrb and write.
  - Write → WR_ADDR_DATA.
  - Read → RD_ADDR.
- WR_ADDR_DATA: `awvalid` and `wvalid` are asserted together.
  - Each channel drops independently after its own handshake, using internal aw_done and w_done flags.
  - Both channels may complete in the same cycle or in either order.
  - When both are done → WR_RESP.
- WR_RESP: `bready`=1. On B handshake, capture bresp → RESP.
- RD_ADDR: `arvalid`=1. On AR handshake → RD_DATA.
- RD_DATA: `rready`=1. On R handshake, capture rdata and rresp → RESP.
- RESP: `rsp_valid`=1 and outputs are stable. When `rsp_ready`=1 → IDLE.
- `awprot` and `arprot` are fixed at 3'b000.
- Once asserted, VALID is never withdrawn before its READY; no combinational path from any READY to any VALID.
- Timeout:
  - A wait counter clears on entry to each wait state and increments every cycle spent in WR_ADDR_DATA, WR_RESP, RD_ADDR or RD_DATA.
  - When the counter reaches TIMEOUT_CYCLES, `timeout` is set. The transaction is not aborted.
  - `timeout_clr` clears the flag. If set and clear happen in the same cycle, set wins.
- Counter width is clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.

## Timing
- Reset values:
  - All AXI VALID and READY outputs 0; `rsp_valid`=0; `timeout`=0.
  - `rsp_rdata`=0, `rsp_resp`=0, AXI addr/data/strb outputs 0.
  - State is IDLE, so `cmd_ready`=1 as soon as reset is released.
- `cmd_ready` is decoded from the state register. All other outputs are registered.
- Command handshake at edge T:
  - First AXI VALID appears after edge T.
  - With an always-ready slave that gives a same-cycle response, the address handshake occurs at T+1, B/R VALID is seen at T+2, and `rsp_valid` rises after T+2. Minimum command-to-response latency is 3 cycles for both reads and writes.
- Response handshake at edge U: `cmd_ready` rises after U. Back-to-back throughput is one command per 4 cycles, minimum.
- Reset asserted mid-transaction: every output returns to its reset value immediately, without waiting for a clock edge. The partial transaction is dropped and no response is produced.

## Structure
- Shared package `core_controller_pkg`:
  - state enum;
  - AXI response constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - default address and data widths.
- Single module with no sub-module. The timeout counter is inline.

## Test plan
- Write to 0x0000 with data 0x0000_0001 and wstrb 4'hF, slave always ready, BRESP=OKAY → AW and W handshake in the same cycle; `rsp_valid` 3 cycles after the command; `rsp_resp`=0, `rsp_rdata`=0.
- Write with AWREADY delayed 3 cycles and WREADY immediate → `wvalid` drops after 1 cycle; `awvalid` held 4 cycles with addr stable; exactly one B accepted.
- Read from 0x0004, slave returns 0x0000_00A5 with RRESP=OKAY after 2 wait cycles → `rsp_rdata`=0x0000_00A5, `rsp_resp`=0.
- Read answered with RRESP=SLVERR, and `rsp_ready` held low for 5 cycles → `rsp_valid` stays high with `rsp_resp`=2'b10 and data stable; `cmd_ready` stays 0 until the response is accepted.
- TIMEOUT_CYCLES=8, ARREADY held low for 20 cycles → `timeout` set on the 8th wait cycle; read still completes; `timeout_clr` pulse clears the flag.
- Reset asserted while in WR_RESP → all VALIDs and `rsp_valid` go to 0 immediately; after release, `cmd_ready`=1 and a new read completes normally.

Source files
------------

// File: rtl/core_controller_pkg.sv
// -----------------------------------------------------------------------------
// core_controller_pkg
// Shared definitions for the core controller AXI4-Lite command master:
//   - master FSM state encoding
//   - AXI response codes
//   - default AXI address / data widths
// -----------------------------------------------------------------------------
package core_controller_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 16;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WR_ADDR_DATA = 3'd1,
    ST_WR_RESP      = 3'd2,
    ST_RD_ADDR      = 3'd3,
    ST_RD_DATA      = 3'd4,
    ST_RESP         = 3'd5
  } state_t;

  // States in which the master is waiting on the slave; the stall
  // counter runs only in these.
  function automatic logic is_wait_state(input state_t s);
    logic w_wait;
    case (s)
      ST_WR_ADDR_DATA, ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA: w_wait = 1'b1;
      default:                                             w_wait = 1'b0;
    endcase
    return w_wait;
  endfunction

endpackage

// File: rtl/core_controller_axil_master.sv
// -----------------------------------------------------------------------------
// core_controller_axil_master
// Converts single-beat register commands (valid/ready) into AXI4-Lite read or
// write transactions, one outstanding at a time, and returns the read data and
// AXI response code on a valid/ready response port. A sticky timeout flag
// reports any single wait on the slave lasting TIMEOUT_CYCLES cycles; the
// transaction itself is never aborted.
//
// Ports
//   m_axi_aclk / m_axi_aresetn : clock, asynchronous active-low reset
//   cmd_*                      : command in (write flag, addr, wdata, wstrb)
//   rsp_*                      : response out (rdata, resp), held until accepted
//   timeout / timeout_clr      : sticky stall flag and its clear
//   m_axi_aw*/w*/b*/ar*/r*     : AXI4-Lite master channels
//
// All outputs except cmd_ready are registered; cmd_ready is decoded from the
// state register, so no READY input reaches any VALID output combinationally.
// -----------------------------------------------------------------------------
module core_controller_axil_master
  import core_controller_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = DEFAULT_DATA_W,
  parameter int C_M_AXI_ADDR_WIDTH = DEFAULT_ADDR_W,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                              m_axi_aclk,
  input  logic                              m_axi_aresetn,
  // command port
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  // response port
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  // stall reporting
  output logic                              timeout,
  input  logic                              timeout_clr,
  // AXI4-Lite write address
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                        m_axi_awprot,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  // AXI4-Lite write data
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  // AXI4-Lite write response
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready,
  // AXI4-Lite read address
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                        m_axi_arprot,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  // AXI4-Lite read data
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                        m_axi_rresp,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready
);

  localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_SET = CNT_W'(TIMEOUT_CYCLES - 1);

  // FSM state and control registers
  state_t r_state;
  state_t w_state_nxt;
  logic   r_awvalid, w_awvalid_nxt;
  logic   r_wvalid,  w_wvalid_nxt;
  logic   r_bready,  w_bready_nxt;
  logic   r_arvalid, w_arvalid_nxt;
  logic   r_rready,  w_rready_nxt;
  logic   r_rsp_valid, w_rsp_valid_nxt;
  logic   r_aw_done, w_aw_done_nxt;
  logic   r_w_done,  w_w_done_nxt;

  // Latched command and captured response
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [C_M_AXI_DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]             r_wstrb;
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_araddr;
  logic [C_M_AXI_DATA_WIDTH-1:0] r_rsp_rdata;
  logic [1:0]                    r_rsp_resp;

  // Stall counter
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_in_wait;
  logic             w_to_set;
  logic             r_timeout;

  // Handshakes
  logic w_cmd_ready;
  logic w_cmd_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_done_now;
  logic w_w_done_now;

  assign w_cmd_ready   = (r_state == ST_IDLE);
  assign w_cmd_hs      = cmd_valid & w_cmd_ready;
  assign w_aw_hs       = r_awvalid & m_axi_awready;
  assign w_w_hs        = r_wvalid & m_axi_wready;
  // "done" includes a handshake happening this cycle, so AW and W may
  // finish together or in either order.
  assign w_aw_done_now = r_aw_done | w_aw_hs;
  assign w_w_done_now  = r_w_done | w_w_hs;

  // ---------------------------------------------------------------------------
  // Next-state and next-control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_awvalid_nxt   = r_awvalid;
    w_wvalid_nxt    = r_wvalid;
    w_bready_nxt    = r_bready;
    w_arvalid_nxt   = r_arvalid;
    w_rready_nxt    = r_rready;
    w_rsp_valid_nxt = r_rsp_valid;
    w_aw_done_nxt   = r_aw_done;
    w_w_done_nxt    = r_w_done;

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_write) begin
            w_state_nxt   = ST_WR_ADDR_DATA;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_aw_done_nxt = 1'b0;
            w_w_done_nxt  = 1'b0;
          end else begin
            w_state_nxt   = ST_RD_ADDR;
            w_arvalid_nxt = 1'b1;
          end
        end
      end

      ST_WR_ADDR_DATA: begin
        if (w_aw_hs) w_awvalid_nxt = 1'b0;
        if (w_w_hs)  w_wvalid_nxt  = 1'b0;
        w_aw_done_nxt = w_aw_done_now;
        w_w_done_nxt  = w_w_done_now;
        if (w_aw_done_now && w_w_done_now) begin
          w_state_nxt  = ST_WR_RESP;
          w_bready_nxt = 1'b1;
        end
      end

      ST_WR_RESP: begin
        if (m_axi_bvalid) begin
          w_state_nxt     = ST_RESP;
          w_bready_nxt    = 1'b0;
          w_rsp_valid_nxt = 1'b1;
        end
      end

      ST_RD_ADDR: begin
        if (m_axi_arready) begin
          w_state_nxt   = ST_RD_DATA;
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
        end
      end

      ST_RD_DATA: begin
        if (m_axi_rvalid) begin
          w_state_nxt     = ST_RESP;
          w_rready_nxt    = 1'b0;
          w_rsp_valid_nxt = 1'b1;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt     = ST_IDLE;
          w_rsp_valid_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_awvalid_nxt   = 1'b0;
        w_wvalid_nxt    = 1'b0;
        w_bready_nxt    = 1'b0;
        w_arvalid_nxt   = 1'b0;
        w_rready_nxt    = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_aw_done_nxt   = 1'b0;
        w_w_done_nxt    = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_state     <= ST_IDLE;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_bready    <= w_bready_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_rready    <= w_rready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_aw_done   <= w_aw_done_nxt;
      r_w_done    <= w_w_done_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Command latch and response capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_araddr    <= '0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= AXI_RESP_OKAY;
    end else begin
      if (w_cmd_hs) begin
        if (cmd_write) begin
          r_awaddr <= cmd_addr;
          r_wdata  <= cmd_wdata;
          r_wstrb  <= cmd_wstrb;
        end else begin
          r_araddr <= cmd_addr;
        end
      end
      // bready is high throughout WR_RESP, so bvalid alone marks the handshake
      if (r_state == ST_WR_RESP && m_axi_bvalid) begin
        r_rsp_rdata <= '0;
        r_rsp_resp  <= m_axi_bresp;
      end
      if (r_state == ST_RD_DATA && m_axi_rvalid) begin
        r_rsp_rdata <= m_axi_rdata;
        r_rsp_resp  <= m_axi_rresp;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stall counter and sticky timeout flag
  // ---------------------------------------------------------------------------
  assign w_in_wait = is_wait_state(r_state);
  assign w_cnt_inc = (r_wait_cnt == CNT_MAX) ? CNT_MAX : r_wait_cnt + CNT_W'(1);
  // Fire once, on the edge that closes the TIMEOUT_CYCLES-th cycle of a
  // wait; after that the counter sits at CNT_MAX so a clear is not
  // immediately overridden while the slave keeps stalling.
  assign w_to_set  = w_in_wait && (r_wait_cnt == CNT_SET);

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_state_nxt != r_state) begin
        r_wait_cnt <= '0;
      end else if (w_in_wait) begin
        r_wait_cnt <= w_cnt_inc;
      end
      if (w_to_set) begin
        r_timeout <= 1'b1;
      end else if (timeout_clr) begin
        r_timeout <= 1'b0;
      end
    end
  end

  assign cmd_ready     = w_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign timeout       = r_timeout;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_core_controller_axil_master.sv
// -----------------------------------------------------------------------------
// tb_core_controller_axil_master
// Directed and randomized transactions against core_controller_axil_master
// with TIMEOUT_CYCLES=8. The slave side is driven cycle by cycle from the main
// sequence; expectations (latency, counts, response, timeout cycle) come from
// per-transaction delay arithmetic.
// -----------------------------------------------------------------------------
module tb_core_controller_axil_master;
  import core_controller_pkg::*;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          timeout, timeout_clr;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]    m_axi_awprot, m_axi_arprot;
  logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]    m_axi_wstrb;
  logic [1:0]    m_axi_bresp, m_axi_rresp;
  logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic          m_axi_rvalid, m_axi_rready;

  int checks = 0;
  int errors = 0;
  bit m_timeout;        // model of the sticky timeout flag
  int last_aw_k, last_w_k;

  always #5 clk = ~clk;

  core_controller_axil_master #(
    .C_M_AXI_DATA_WIDTH(DW),
    .C_M_AXI_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES    (TO)
  ) dut (
    .m_axi_aclk   (clk),
    .m_axi_aresetn(rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .timeout      (timeout),
    .timeout_clr  (timeout_clr),
    .m_axi_awaddr (m_axi_awaddr),
    .m_axi_awprot (m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata  (m_axi_wdata),
    .m_axi_wstrb  (m_axi_wstrb),
    .m_axi_wvalid (m_axi_wvalid),
    .m_axi_wready (m_axi_wready),
    .m_axi_bresp  (m_axi_bresp),
    .m_axi_bvalid (m_axi_bvalid),
    .m_axi_bready (m_axi_bready),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arprot (m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rresp  (m_axi_rresp),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_quiet();
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    m_axi_bresp   = 2'b00;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
  endtask

  // One complete transaction. d_a: cycles AWREADY/ARREADY is held off,
  // d_w: cycles WREADY is held off, d_rsp: cycles between the address phase
  // completing and B/R VALID, hold: cycles rsp_ready is held low.
  task automatic run_txn(input string tag, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [3:0] strb,
                         input int d_a, input int d_w, input int d_rsp,
                         input logic [1:0] resp, input logic [DW-1:0] rd, input int hold);
    int k, aw_k, w_k, ar_k, x_k, rsp_k, to_k;
    int aw_n, w_n, ar_n, x_n, bad, hold_bad;
    int len1, len2, lat_exp, to_exp;
    logic [DW-1:0] rdata_exp;
    logic [DW-1:0] rd0;
    logic [1:0]    rs0;

    len1      = wr ? (((d_a > d_w) ? d_a : d_w) + 1) : (d_a + 1);
    len2      = d_rsp + 1;
    lat_exp   = len1 + len2;
    to_exp    = m_timeout ? 0 : ((len1 >= TO) ? TO : ((len2 >= TO) ? len1 + TO : -1));
    rdata_exp = wr ? '0 : rd;

    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = strb;
    step();
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = AW'($urandom());
    cmd_wdata = $urandom();
    cmd_wstrb = 4'($urandom());

    k = 0; aw_k = -1; w_k = -1; ar_k = -1; x_k = -1; rsp_k = -1; to_k = -1;
    aw_n = 0; w_n = 0; ar_n = 0; x_n = 0; bad = 0; hold_bad = 0;
    while (rsp_k < 0 && k < 200) begin
      if (m_axi_awvalid) begin aw_n++; if (m_axi_awaddr !== addr) bad = 1; end
      if (m_axi_wvalid) begin
        w_n++;
        if (m_axi_wdata !== wd || m_axi_wstrb !== strb) bad = 1;
      end
      if (m_axi_arvalid) begin ar_n++; if (m_axi_araddr !== addr) bad = 1; end
      if (m_axi_awprot !== 3'b000 || m_axi_arprot !== 3'b000) bad = 1;
      if (timeout && to_k < 0) to_k = k;
      if (wr) begin
        m_axi_awready = (aw_k < 0 && k >= d_a);
        m_axi_wready  = (w_k < 0 && k >= d_w);
        m_axi_bvalid  = (aw_k >= 0 && w_k >= 0 && x_k < 0 &&
                         k >= ((aw_k > w_k) ? aw_k : w_k) + 1 + d_rsp);
        m_axi_bresp   = resp;
        if (m_axi_awvalid && m_axi_awready) aw_k = k;
        if (m_axi_wvalid && m_axi_wready) w_k = k;
        if (m_axi_bvalid && m_axi_bready) begin x_k = k; x_n++; end
      end else begin
        m_axi_arready = (ar_k < 0 && k >= d_a);
        m_axi_rvalid  = (ar_k >= 0 && x_k < 0 && k >= ar_k + 1 + d_rsp);
        m_axi_rdata   = rd;
        m_axi_rresp   = resp;
        if (m_axi_arvalid && m_axi_arready) ar_k = k;
        if (m_axi_rvalid && m_axi_rready) begin x_k = k; x_n++; end
      end
      if (rsp_valid) rsp_k = k;
      else begin step(); k++; end
    end
    slave_quiet();
    last_aw_k = aw_k;
    last_w_k  = w_k;

    chk({tag, "_latency"}, 32'(rsp_k), 32'(lat_exp));
    if (rsp_k < 0) return;
    chk({tag, "_rdata"}, rsp_rdata, rdata_exp);
    chk({tag, "_resp"}, 32'(rsp_resp), 32'(resp));
    chk({tag, "_aw_cycles"}, 32'(aw_n), wr ? 32'(d_a + 1) : 32'd0);
    chk({tag, "_w_cycles"}, 32'(w_n), wr ? 32'(d_w + 1) : 32'd0);
    chk({tag, "_ar_cycles"}, 32'(ar_n), wr ? 32'd0 : 32'(d_a + 1));
    chk({tag, "_resp_beats"}, 32'(x_n), 32'd1);
    chk({tag, "_addr_data_stable"}, 32'(bad), 32'd0);
    chk({tag, "_timeout_cycle"}, 32'(to_k), 32'(to_exp));
    chk({tag, "_quiet_in_resp"}, 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                                       m_axi_arvalid, m_axi_rready, cmd_ready}), 32'd0);
    if (to_exp >= 0) m_timeout = 1'b1;

    rd0 = rsp_rdata;
    rs0 = rsp_resp;
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd0 || rsp_resp !== rs0 || cmd_ready !== 1'b0)
        hold_bad = 1;
    end
    chk({tag, "_rsp_hold"}, 32'(hold_bad), 32'd0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, "_after_accept"}, 32'({rsp_valid, cmd_ready}), 32'b01);
    chk({tag, "_timeout_flag"}, 32'(timeout), 32'(m_timeout));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=done");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] resp_tab [4];
    bit         nb;
    bit         wr;
    int         bad;

    resp_tab = '{AXI_RESP_OKAY, AXI_RESP_EXOKAY, AXI_RESP_SLVERR, AXI_RESP_DECERR};
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0; timeout_clr = 1'b0;
    m_timeout = 1'b0;
    slave_quiet();
    repeat (3) step();

    // reset values
    chk("reset_ctrl", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                            m_axi_rready, rsp_valid, timeout}), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_rsp", 32'(rsp_rdata) | 32'(rsp_resp), 32'd0);
    chk("reset_axi_addr", 32'(m_axi_awaddr) | 32'(m_axi_araddr), 32'd0);
    chk("reset_axi_data", m_axi_wdata | 32'(m_axi_wstrb), 32'd0);
    step();
    chk("idle_after_reset", 32'({m_axi_awvalid, m_axi_arvalid, rsp_valid, cmd_ready}), 32'b0001);

    // write, always-ready slave
    run_txn("wr_basic", 1'b1, 16'h0000, 32'h0000_0001, 4'hF, 0, 0, 0, AXI_RESP_OKAY, 32'h0, 0);
    chk("wr_basic_aw_k", 32'(last_aw_k), 32'd0);
    chk("wr_basic_w_k", 32'(last_w_k), 32'd0);

    // AWREADY delayed 3 cycles, WREADY immediate
    run_txn("wr_aw_late", 1'b1, 16'h0010, 32'hCAFE_F00D, 4'h5, 3, 0, 0, AXI_RESP_OKAY, 32'h0, 0);
    // WREADY delayed instead, non-OKAY response
    run_txn("wr_w_late", 1'b1, 16'h0020, 32'h1234_5678, 4'hC, 0, 2, 1, AXI_RESP_DECERR, 32'h0, 1);

    // read from 0x0004 with two wait cycles on R
    run_txn("rd_a5", 1'b0, 16'h0004, 32'h0, 4'h0, 0, 0, 2, AXI_RESP_OKAY, 32'h0000_00A5, 0);

    // SLVERR with response back-pressure
    run_txn("rd_slverr", 1'b0, 16'h0008, 32'h0, 4'h0, 1, 0, 0, AXI_RESP_SLVERR,
            32'hDEAD_BEEF, 5);

    // ARREADY held low for 20 cycles
    run_txn("rd_timeout", 1'b0, 16'h000C, 32'h0, 4'h0, 20, 0, 0, AXI_RESP_OKAY,
            32'h0BAD_0001, 0);
    timeout_clr = 1'b1;
    step();
    timeout_clr = 1'b0;
    m_timeout = 1'b0;
    chk("timeout_cleared", 32'(timeout), 32'd0);

    // reset while waiting in WR_RESP
    chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0040;
    cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF;
    step();
    cmd_valid = 1'b0;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    step();
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    chk("rst_mid_in_wr_resp", 32'(m_axi_bready), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_async_ctrl", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                                    m_axi_rready, rsp_valid, timeout}), 32'd0);
    chk("rst_mid_async_data", 32'(m_axi_awaddr) | m_axi_wdata | rsp_rdata, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    m_timeout = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad = 1;
    end
    chk("rst_mid_no_response", 32'(bad), 32'd0);
    run_txn("rd_after_rst", 1'b0, 16'h0044, 32'h0, 4'h0, 0, 0, 1, AXI_RESP_OKAY,
            32'h0000_0077, 0);

    // randomized transactions
    for (int i = 0; i < 12; i++) begin
      nb = 1'($urandom_range(0, 1));
      wr = nb;
      run_txn($sformatf("rnd%0d", i), wr, AW'($urandom_range(0, 16383) << 2), $urandom(),
              4'($urandom()), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), resp_tab[$urandom_range(0, 3)], $urandom(),
              int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
